// File: rtl/dm_responder_if.sv
// ----------------------------------------------------------------------------
// dm_responder_if
//   Bundle of the M-stage data-memory request/response signals.
//
//   Request (driven by the pipeline / master side):
//     req_valid  - request present, held until resp_valid
//     req_we     - 1 = store, 0 = load
//     req_addr   - byte address
//     req_wdata  - store data
//     req_op     - 00 word, 01 half, 10 byte signed, 11 byte unsigned
//   Response (driven by the responder / slave side):
//     stall      - freeze F/D/E/M while the access is in flight
//     resp_valid - one-cycle completion pulse
//     resp_rdata - load result, valid only with resp_valid
//     resp_err   - misaligned access, valid only with resp_valid
// ----------------------------------------------------------------------------
interface dm_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_op;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_op,
        input  stall, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_op,
        output stall, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_responder.sv
// ----------------------------------------------------------------------------
// dm_responder
//   Data-memory responder for the M stage. Serves word/half/byte loads and
//   stores with a fixed wait-state latency, stalls the pipeline while an
//   access is in flight and flags misaligned accesses instead of doing them.
//
//   Parameters:
//     DEPTH_LOG2 - memory holds 2**DEPTH_LOG2 32-bit words
//     LATENCY    - cycles from acceptance to resp_valid (1..15)
//
//   Ports:
//     clk   - clock
//     reset - synchronous, active-low reset (also clears the memory)
//     bus   - dm_responder_if.slave request/response bundle
// ----------------------------------------------------------------------------
module dm_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic          clk,
    input  logic          reset,
    dm_responder_if.slave bus
);

    localparam int         WORDS     = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAST_WAIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        commit;

    logic [31:0] mem [0:WORDS-1];

    logic [DEPTH_LOG2-1:0] word_idx;
    logic [31:0] cur_word;
    logic        misaligned;
    logic [3:0]  lane_en;
    logic [31:0] lane_data;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [31:0] load_data;

    logic [31:0] rdata_q;
    logic        err_q;

    // Address bits above the word index are deliberately ignored so that
    // accesses wrap modulo the memory size.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:DEPTH_LOG2+2];

    // Address decode, lane enables for stores and lane selection for loads.
    always_comb begin
        word_idx   = bus.req_addr[DEPTH_LOG2+1:2];
        cur_word   = mem[word_idx];
        misaligned = 1'b0;
        lane_en    = 4'b0000;
        lane_data  = bus.req_wdata;

        case (bus.req_op)
            2'b00: begin
                misaligned = (bus.req_addr[1:0] != 2'b00);
                lane_en    = 4'b1111;
                lane_data  = bus.req_wdata;
            end
            2'b01: begin
                misaligned = bus.req_addr[0];
                lane_en    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                lane_data  = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                lane_en    = 4'b0001 << bus.req_addr[1:0];
                lane_data  = {4{bus.req_wdata[7:0]}};
            end
        endcase

        half_sel = bus.req_addr[1] ? cur_word[31:16] : cur_word[15:0];

        case (bus.req_addr[1:0])
            2'b00:   byte_sel = cur_word[7:0];
            2'b01:   byte_sel = cur_word[15:8];
            2'b10:   byte_sel = cur_word[23:16];
            default: byte_sel = cur_word[31:24];
        endcase

        case (bus.req_op)
            2'b00:   load_data = cur_word;
            2'b01:   load_data = {{16{half_sel[15]}}, half_sel};
            2'b10:   load_data = {{24{byte_sel[7]}}, byte_sel};
            default: load_data = {24'h000000, byte_sel};
        endcase
    end

    // Next-state logic. commit marks the edge that enters RESP; both the
    // memory write and the load-data capture happen on that edge. RESP
    // always returns to IDLE without looking at req_valid, so the request
    // that just completed cannot be accepted a second time.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                        cnt_nxt   = 4'd0;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'd1;
                    end
                end
            end
            WAIT: begin
                if (cnt == LAST_WAIT) begin
                    state_nxt = RESP;
                    cnt_nxt   = 4'd0;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State register plus the response registers, which only hold a value
    // for the single RESP cycle and are zero otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (commit) begin
                rdata_q <= (misaligned || bus.req_we) ? 32'h0 : load_data;
                err_q   <= misaligned;
            end else begin
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
        end
    end

    // Memory array. Reset clears every word; a store writes only its enabled
    // lanes and a misaligned store writes nothing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (commit && bus.req_we && !misaligned) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_en[k]) begin
                    mem[word_idx][8*k +: 8] <= lane_data[8*k +: 8];
                end
            end
        end
    end

    // Outputs are forced low while reset is held so the pipeline sees a
    // quiet memory even if the state register has not been cleared yet.
    assign bus.stall      = reset & (((state == IDLE) & bus.req_valid) | (state == WAIT));
    assign bus.resp_valid = reset & (state == RESP);
    assign bus.resp_rdata = reset ? rdata_q : 32'h0;
    assign bus.resp_err   = reset & err_q;

endmodule

// File: tb/tb_dm_responder.sv
// ----------------------------------------------------------------------------
// tb_dm_responder
//   Directed testbench for dm_responder. Three instances share one clock and
//   reset: LATENCY=2, LATENCY=1 and LATENCY=4 (all DEPTH_LOG2=10). The request
//   fields are common; req_valid is steered to the instance chosen by sel and
//   that instance's outputs are muxed onto the obs_* signals.
// ----------------------------------------------------------------------------
module tb_dm_responder;

    logic        clk;
    logic        reset;
    logic [1:0]  sel;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_op;

    logic        obs_stall;
    logic        obs_valid;
    logic [31:0] obs_rdata;
    logic        obs_err;

    int cyc;
    int total;
    int bad;

    dm_responder_if bus_l2 ();
    dm_responder_if bus_l1 ();
    dm_responder_if bus_l4 ();

    assign bus_l2.req_valid = req_valid && (sel == 2'd0);
    assign bus_l2.req_we    = req_we;
    assign bus_l2.req_addr  = req_addr;
    assign bus_l2.req_wdata = req_wdata;
    assign bus_l2.req_op    = req_op;

    assign bus_l1.req_valid = req_valid && (sel == 2'd1);
    assign bus_l1.req_we    = req_we;
    assign bus_l1.req_addr  = req_addr;
    assign bus_l1.req_wdata = req_wdata;
    assign bus_l1.req_op    = req_op;

    assign bus_l4.req_valid = req_valid && (sel == 2'd2);
    assign bus_l4.req_we    = req_we;
    assign bus_l4.req_addr  = req_addr;
    assign bus_l4.req_wdata = req_wdata;
    assign bus_l4.req_op    = req_op;

    dm_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut_l2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l2)
    );

    dm_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut_l1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l1)
    );

    dm_responder #(.DEPTH_LOG2(10), .LATENCY(4)) dut_l4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l4)
    );

    always_comb begin
        case (sel)
            2'd1: begin
                obs_stall = bus_l1.stall;
                obs_valid = bus_l1.resp_valid;
                obs_rdata = bus_l1.resp_rdata;
                obs_err   = bus_l1.resp_err;
            end
            2'd2: begin
                obs_stall = bus_l4.stall;
                obs_valid = bus_l4.resp_valid;
                obs_rdata = bus_l4.resp_rdata;
                obs_err   = bus_l4.resp_err;
            end
            default: begin
                obs_stall = bus_l2.stall;
                obs_valid = bus_l2.resp_valid;
                obs_rdata = bus_l2.resp_rdata;
                obs_err   = bus_l2.resp_err;
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Presents one request starting in the current cycle, waits (bounded) for
    // the completion pulse, then drops req_valid after the RESP cycle ends.
    // resp_cyc stays -1 if no pulse arrives.
    task automatic run_access(
        input  logic        we,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [1:0]  op,
        output int          start_cyc,
        output int          resp_cyc,
        output int          stall_cnt,
        output logic [31:0] rdata,
        output logic        err
    );
        start_cyc = cyc;
        resp_cyc  = -1;
        stall_cnt = 0;
        rdata     = 32'hxxxxxxxx;
        err       = 1'bx;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_op    = op;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (obs_stall) stall_cnt++;
            if (obs_valid) begin
                resp_cyc = cyc;
                rdata    = obs_rdata;
                err      = obs_err;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        sel       = 2'd0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_op    = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            total++;
            if (obs_stall !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_stall sel=%0d: got %b want 0", s, obs_stall);
            end
            total++;
            if (obs_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_valid sel=%0d: got %b want 0", s, obs_valid);
            end
            total++;
            if (obs_rdata !== 32'h0 || obs_err !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_data sel=%0d: got rdata=%h err=%b want 0/0", s, obs_rdata, obs_err);
            end
        end
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        sel       = 2'd0;
        @(negedge clk);
        total++;
        if (obs_stall !== 1'b0 || obs_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_after_reset: got stall=%b valid=%b want 0/0", obs_stall, obs_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load();
        int t0, t1, sc;
        logic [31:0] rd;
        logic er;
        sel = 2'd0;
        run_access(1'b1, 32'h10, 32'h12345678, 2'b00, t0, t1, sc, rd, er);
        total++;
        if (t1 - t0 !== 2) begin
            bad++;
            $display("[TB] FAIL sw_latency: got %0d want 2", t1 - t0);
        end
        total++;
        if (sc !== 2) begin
            bad++;
            $display("[TB] FAIL sw_stall_cycles: got %0d want 2", sc);
        end
        total++;
        if (er !== 1'b0) begin
            bad++;
            $display("[TB] FAIL sw_err: got %b want 0", er);
        end
        @(negedge clk);
        total++;
        if (obs_valid !== 1'b0 || obs_rdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL pulse_width: got valid=%b rdata=%h want 0/0", obs_valid, obs_rdata);
        end
        @(posedge clk);
        #1;
        run_access(1'b0, 32'h10, 32'h0, 2'b00, t0, t1, sc, rd, er);
        total++;
        if (rd !== 32'h12345678 || er !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lw_0x10: got %h err=%b want 12345678 err=0", rd, er);
        end
        total++;
        if (t1 - t0 !== 2) begin
            bad++;
            $display("[TB] FAIL lw_latency: got %0d want 2", t1 - t0);
        end
    endtask

    task automatic test_merge();
        int t0, t1, sc;
        logic [31:0] rd;
        logic er;
        sel = 2'd0;
        run_access(1'b1, 32'h20, 32'hAABBCCDD, 2'b00, t0, t1, sc, rd, er);
        run_access(1'b1, 32'h22, 32'h0000007F, 2'b10, t0, t1, sc, rd, er);
        run_access(1'b1, 32'h20, 32'h00008001, 2'b01, t0, t1, sc, rd, er);
        run_access(1'b0, 32'h20, 32'h0, 2'b00, t0, t1, sc, rd, er);
        total++;
        if (rd !== 32'hAA7F8001) begin
            bad++;
            $display("[TB] FAIL merge_word: got %h want aa7f8001", rd);
        end
    endtask

    task automatic test_extend();
        int t0, t1, sc;
        logic [31:0] rd;
        logic er;
        logic [31:0] addrs [5];
        logic [1:0]  ops   [5];
        logic [31:0] wants [5];
        addrs = '{32'h32, 32'h31, 32'h33, 32'h32, 32'h30};
        ops   = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b01};
        wants = '{32'hFFFF80FF, 32'h0000007F, 32'hFFFFFF80, 32'h000000FF, 32'h00007F01};
        sel = 2'd0;
        run_access(1'b1, 32'h30, 32'h80FF7F01, 2'b00, t0, t1, sc, rd, er);
        for (int i = 0; i < 5; i++) begin
            run_access(1'b0, addrs[i], 32'h0, ops[i], t0, t1, sc, rd, er);
            total++;
            if (rd !== wants[i] || er !== 1'b0) begin
                bad++;
                $display("[TB] FAIL extend_%0d addr=%h op=%b: got %h err=%b want %h err=0",
                         i, addrs[i], ops[i], rd, er, wants[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        int t0, t1, sc;
        logic [31:0] rd;
        logic er;
        sel = 2'd0;
        run_access(1'b1, 32'h41, 32'hCAFEF00D, 2'b00, t0, t1, sc, rd, er);
        total++;
        if (er !== 1'b1 || rd !== 32'h0 || t1 - t0 !== 2) begin
            bad++;
            $display("[TB] FAIL mis_sw_0x41: got err=%b rdata=%h lat=%0d want 1/0/2", er, rd, t1 - t0);
        end
        run_access(1'b0, 32'h43, 32'h0, 2'b01, t0, t1, sc, rd, er);
        total++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            bad++;
            $display("[TB] FAIL mis_lh_0x43: got err=%b rdata=%h want 1/0", er, rd);
        end
        run_access(1'b0, 32'h12, 32'h0, 2'b00, t0, t1, sc, rd, er);
        total++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            bad++;
            $display("[TB] FAIL mis_lw_0x12: got err=%b rdata=%h want 1/0", er, rd);
        end
        run_access(1'b0, 32'h40, 32'h0, 2'b00, t0, t1, sc, rd, er);
        total++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            bad++;
            $display("[TB] FAIL word_0x40_untouched: got err=%b rdata=%h want 0/0", er, rd);
        end
    endtask

    task automatic test_back_to_back();
        int t0, t1, sc;
        int ta, ra, sa;
        int tb, rb, sb;
        logic [31:0] rd_a, rd_b, rd;
        logic er, er_a, er_b;
        sel = 2'd1;
        run_access(1'b1, 32'h0010, 32'h5555AAAA, 2'b00, t0, t1, sc, rd, er);
        total++;
        if (t1 - t0 !== 1 || sc !== 1) begin
            bad++;
            $display("[TB] FAIL l1_store: got lat=%0d stall=%0d want 1/1", t1 - t0, sc);
        end
        run_access(1'b0, 32'h1010, 32'h0, 2'b00, ta, ra, sa, rd_a, er_a);
        run_access(1'b0, 32'h0010, 32'h0, 2'b00, tb, rb, sb, rd_b, er_b);
        total++;
        if (ra !== ta + 1 || rb !== ta + 3) begin
            bad++;
            $display("[TB] FAIL b2b_resp_cycles: got T+%0d,T+%0d want T+1,T+3", ra - ta, rb - ta);
        end
        total++;
        if (tb !== ta + 2 || sa !== 1 || sb !== 1) begin
            bad++;
            $display("[TB] FAIL b2b_stall: got accept2=T+%0d stalls=%0d,%0d want T+2 1,1", tb - ta, sa, sb);
        end
        total++;
        if (rd_a !== 32'h5555AAAA || rd_b !== 32'h5555AAAA || er_a !== 1'b0 || er_b !== 1'b0) begin
            bad++;
            $display("[TB] FAIL alias_0x1010: got %h,%h want 5555aaaa,5555aaaa", rd_a, rd_b);
        end
    endtask

    task automatic test_reset_mid_wait();
        int t0, t1, sc;
        int seen;
        logic [31:0] rd;
        logic er;
        sel       = 2'd2;
        req_we    = 1'b1;
        req_addr  = 32'h50;
        req_wdata = 32'hDEADBEEF;
        req_op    = 2'b00;
        req_valid = 1'b1;
        @(negedge clk);
        total++;
        if (obs_stall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL l4_accept_stall: got %b want 1", obs_stall);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (obs_stall !== 1'b0 || obs_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_wait_reset: got stall=%b valid=%b want 0/0", obs_stall, obs_valid);
        end
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        seen      = 0;
        repeat (6) begin
            @(negedge clk);
            if (obs_valid || obs_stall) seen++;
            @(posedge clk);
            #1;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("[TB] FAIL aborted_activity: got %0d active cycles want 0", seen);
        end
        run_access(1'b0, 32'h50, 32'h0, 2'b00, t0, t1, sc, rd, er);
        total++;
        if (rd !== 32'h0 || er !== 1'b0 || t1 - t0 !== 4) begin
            bad++;
            $display("[TB] FAIL lw_0x50_after_abort: got %h err=%b lat=%0d want 0/0/4", rd, er, t1 - t0);
        end
    endtask

    initial begin
        cyc   = 0;
        total = 0;
        bad   = 0;
        test_reset();
        test_store_load();
        test_merge();
        test_extend();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
